coef_loader: RTL
================

Name: coef_loader

Overview:
- Wishbone classic master that drives the biquad coefficient register slave from the initiator side.
- On a start pulse it latches five coefficients and writes them to a11, a12, b10, b11 and b12.
- It can optionally read the five registers back and compare them, then reads the current x and y samples.
- Sits between the control or management logic and the coefficient slave; reports busy, done and error status.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte address of a11. Register offsets are +0x00 a11, +0x04 a12, +0x08 b10, +0x0C b11, +0x10 b12, +0x14 x, +0x18 y.
- DATAWIDTH, 12, width of the captured x/y samples.
- TIMEOUT, 15, maximum cycles stb_o is held waiting for ack_i before the transfer aborts (range 1..255).

Ports:
- clk_i  in  1  single clock; all logic rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- verify_i  in  1  when 1, perform read-back compare; latched with start_i.
- a11_i, a12_i, b10_i, b11_i, b12_i  in  32 each  coefficient values; latched on accepted start.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  Wishbone write enable.
- adr_o  out  32  Wishbone address.
- dat_o  out  32  Wishbone write data.
- dat_i  in  32  Wishbone read data.
- ack_i  in  1  Wishbone acknowledge.
- busy_o  out  1  high from accepted start until done_o.
- done_o  out  1  one-cycle pulse at end of a sequence, success or error.
- err_o  out  1  sticky error flag; cleared on next accepted start.
- err_idx_o  out  3  transfer index that failed (0..4 = coefficient, 5 = x, 6 = y).
- err_to_o  out  1  1 = error was a timeout, 0 = verify mismatch.
- x_o, y_o  out  DATAWIDTH each  captured samples, dat_i[DATAWIDTH-1:0].

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - cyc_o, stb_o, we_o, busy_o, done_o, err_o and err_to_o are 0.
  - adr_o, dat_o, err_idx_o, x_o and y_o are 0.
  - Latched coefficients are 0; state is IDLE.
- States: IDLE -> WR -> (RB if verify) -> RDX -> RDY -> FIN -> IDLE.
  - Any error goes straight to FIN.
  - Each of WR and RB uses index 0..4.
- IDLE:
  - start_i=1 at an edge latches coefficients and verify_i, clears err_o, err_to_o and err_idx_o, and sets busy_o.
  - The first transfer begins in the next cycle.
  - start_i is ignored while busy_o=1.
- Transfer:
  - cyc_o, stb_o, adr_o, we_o and dat_o are driven together and held constant until ack_i is sampled high at a rising edge.
  - dat_i is captured on that same edge.
  - In the following cycle cyc_o and stb_o are 0 (one-cycle idle gap). The next transfer starts the cycle after that.
  - Wait states are supported: ack_i may arrive any number of cycles after stb_o rises, up to TIMEOUT.
- Write transfers: adr_o = BASE_ADDR + 4*idx, we_o=1, dat_o = latched coefficient. dat_o=0 on reads.
- RB (read-back): we_o=0, same addresses. Captured dat_i must equal the latched coefficient in all 32 bits. On mismatch: err_o=1, err_to_o=0, err_idx_o=idx, go to FIN.
- RDX / RDY: read BASE_ADDR+0x14 and +0x18; x_o / y_o update on the ack edge. Outputs hold their value until the next successful read.
- Timeout:
  - A cycle counter starts at 1 on the first stb_o cycle.
  - If ack_i is still 0 when the counter reaches TIMEOUT, stb_o and cyc_o drop at the next edge.
  - err_o=1, err_to_o=1, err_idx_o = transfer index (WR/RB idx, RDX 5, RDY 6); go to FIN.
- FIN:
  - done_o=1 for exactly one cycle; busy_o falls at the end of that cycle.
  - Bus signals are 0 during FIN.
- Timing with a zero-wait slave (ack_i = stb_o), start accepted at edge 0:
  - stb_o is high in cycles 1, 3, 5, ...
  - Without verify: 7 transfers; final ack at edge 13; done_o high between edges 13 and 14.
  - With verify: 12 transfers; done_o between edges 23 and 24.
- ack_i while stb_o=0 is ignored.
- start_i held high continuously starts a new sequence in the cycle after FIN.

Test Plan:
- Zero-wait slave model, coefficients 0x4001/0xC000/0x2000/0x1000/0x0800, verify=0 -> five writes to 0x3000_0000..0x3000_0010 with matching dat_o, then x/y reads. x_o/y_o equal the slave's 0xABC/0x123. done_o pulses at cycle 13; err_o=0.
- Same stimulus with verify=1 -> five read-backs match; done_o at cycle 23; err_o=0.
- Slave corrupts b10 read-back (returns 0x2001) -> err_o=1, err_to_o=0, err_idx_o=2. No x/y reads are issued; done_o pulses once.
- Slave never acks address 0x3000_000C, TIMEOUT=15 -> stb_o is high exactly 15 cycles, then drops. err_to_o=1, err_idx_o=3; done_o pulses.
- Slave inserting 3 wait states per transfer -> adr_o/dat_o stable while stb_o is high; sequence completes correctly with err_o=0.
- Reset asserted mid-write (index 2), and start_i pulsed while busy -> reset drops cyc_o/stb_o immediately and all outputs read 0. A start while busy causes no restart and no extra transfers.

Source files
------------

// File: rtl/coef_loader.sv
// coef_loader: Wishbone classic master that loads five biquad coefficients
// into the coefficient slave, optionally reads them back for comparison,
// then captures the current x and y samples.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; bus idle
// WR    | writing coefficient idx (0..4)
// RB    | reading back coefficient idx (0..4) and comparing it
// RDX   | reading the x sample
// RDY   | reading the y sample
// FIN   | one-cycle done pulse; bus idle
//
// Each transfer state has two phases: an idle gap cycle (gap=1) and the
// strobed phase (gap=0). A transfer entered from IDLE skips the gap.
module coef_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DATAWIDTH = 12,
  parameter int          TIMEOUT   = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 verify_i,
  input  logic [31:0]          a11_i,
  input  logic [31:0]          a12_i,
  input  logic [31:0]          b10_i,
  input  logic [31:0]          b11_i,
  input  logic [31:0]          b12_i,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [31:0]          adr_o,
  output logic [31:0]          dat_o,
  input  logic [31:0]          dat_i,
  input  logic                 ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [2:0]           err_idx_o,
  output logic                 err_to_o,
  output logic [DATAWIDTH-1:0] x_o,
  output logic [DATAWIDTH-1:0] y_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RB   = 3'd2,
    S_RDX  = 3'd3,
    S_RDY  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  // Timer is a down-counter loaded with TIMEOUT on the first strobe cycle;
  // reaching 1 corresponds to TIMEOUT strobe cycles without an ack.
  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT);

  state_t      state, state_nx;
  logic        gap, gap_nx;
  logic [2:0]  idx, idx_nx;
  logic [7:0]  tmr;
  logic        verify_q;
  logic [31:0] coef_q [0:4];

  logic        in_xfer;
  logic        active;
  logic        acked;
  logic        tmo;
  logic        mismatch;
  logic        accept;
  logic [2:0]  xfer_idx;
  logic [31:0] coef_sel;

  // Decode of the current transfer and its completion conditions
  always_comb begin
    in_xfer  = (state == S_WR) || (state == S_RB) ||
               (state == S_RDX) || (state == S_RDY);
    active   = in_xfer && !gap;
    acked    = active && ack_i;
    tmo      = active && !ack_i && (tmr == 8'd1);
    accept   = (state == S_IDLE) && start_i;
    coef_sel = 32'd0;
    case (idx)
      3'd0:    coef_sel = coef_q[0];
      3'd1:    coef_sel = coef_q[1];
      3'd2:    coef_sel = coef_q[2];
      3'd3:    coef_sel = coef_q[3];
      3'd4:    coef_sel = coef_q[4];
      default: coef_sel = 32'd0;
    endcase
    xfer_idx = 3'd0;
    case (state)
      S_WR, S_RB: xfer_idx = idx;
      S_RDX:      xfer_idx = 3'd5;
      S_RDY:      xfer_idx = 3'd6;
      default:    xfer_idx = 3'd0;
    endcase
    mismatch = (state == S_RB) && acked && (dat_i != coef_sel);
  end

  // State register with transfer phase and index
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      gap   <= 1'b0;
      idx   <= 3'd0;
    end else begin
      state <= state_nx;
      gap   <= gap_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic: sequence through transfers, errors jump to FIN
  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    idx_nx   = idx;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nx = S_WR;
          gap_nx   = 1'b0;
          idx_nx   = 3'd0;
        end
      end
      S_WR: begin
        if (gap) begin
          gap_nx = 1'b0;
        end else if (acked) begin
          gap_nx = 1'b1;
          if (idx == 3'd4) begin
            idx_nx   = 3'd0;
            state_nx = verify_q ? S_RB : S_RDX;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end else if (tmo) begin
          state_nx = S_FIN;
        end
      end
      S_RB: begin
        if (gap) begin
          gap_nx = 1'b0;
        end else if (mismatch) begin
          state_nx = S_FIN;
        end else if (acked) begin
          gap_nx = 1'b1;
          if (idx == 3'd4) begin
            idx_nx   = 3'd0;
            state_nx = S_RDX;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end else if (tmo) begin
          state_nx = S_FIN;
        end
      end
      S_RDX: begin
        if (gap) begin
          gap_nx = 1'b0;
        end else if (acked) begin
          gap_nx   = 1'b1;
          state_nx = S_RDY;
        end else if (tmo) begin
          state_nx = S_FIN;
        end
      end
      S_RDY: begin
        if (gap) begin
          gap_nx = 1'b0;
        end else if (acked || tmo) begin
          state_nx = S_FIN;
        end
      end
      S_FIN: begin
        state_nx = S_IDLE;
        gap_nx   = 1'b0;
        idx_nx   = 3'd0;
      end
      default: begin
        state_nx = S_IDLE;
        gap_nx   = 1'b0;
        idx_nx   = 3'd0;
      end
    endcase
  end

  // Datapath: coefficient latch, error status, sample capture, ack timer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 5; i++) coef_q[i] <= 32'd0;
      verify_q  <= 1'b0;
      err_o     <= 1'b0;
      err_to_o  <= 1'b0;
      err_idx_o <= 3'd0;
      x_o       <= '0;
      y_o       <= '0;
      tmr       <= TMR_LOAD;
    end else begin
      if (accept) begin
        coef_q[0] <= a11_i;
        coef_q[1] <= a12_i;
        coef_q[2] <= b10_i;
        coef_q[3] <= b11_i;
        coef_q[4] <= b12_i;
        verify_q  <= verify_i;
        err_o     <= 1'b0;
        err_to_o  <= 1'b0;
        err_idx_o <= 3'd0;
      end
      if (tmo) begin
        err_o     <= 1'b1;
        err_to_o  <= 1'b1;
        err_idx_o <= xfer_idx;
      end
      if (mismatch) begin
        err_o     <= 1'b1;
        err_to_o  <= 1'b0;
        err_idx_o <= xfer_idx;
      end
      if (acked && (state == S_RDX)) x_o <= dat_i[DATAWIDTH-1:0];
      if (acked && (state == S_RDY)) y_o <= dat_i[DATAWIDTH-1:0];
      // Reloaded whenever no strobe is out, so each transfer starts fresh
      if (active) tmr <= tmr - 8'd1;
      else        tmr <= TMR_LOAD;
    end
  end

  // Output decode: bus signals only during the strobed phase
  always_comb begin
    cyc_o  = active;
    stb_o  = active;
    we_o   = active && (state == S_WR);
    adr_o  = active ? (BASE_ADDR + {27'd0, xfer_idx, 2'b00}) : 32'd0;
    dat_o  = (active && (state == S_WR)) ? coef_sel : 32'd0;
    busy_o = (state != S_IDLE);
    done_o = (state == S_FIN);
  end

endmodule
